// File: rtl/exu_issue_ctrl_pkg.sv
// Shared execution-unit definitions: functional-unit codes and unit latencies.
`ifndef EXU_ISSUE_CTRL_PKG_SV
`define EXU_ISSUE_CTRL_PKG_SV

`define IMUL_LATENCY 3
`define IDIV_LATENCY 8

package exu_issue_ctrl_pkg;

  typedef enum logic [1:0] {
    FU_ALU  = 2'd0,
    FU_IMUL = 2'd1,
    FU_IDIV = 2'd2,
    FU_RSVD = 2'd3
  } fu_code_t;

endpackage

`endif

// File: rtl/exu_idiv_timer.sv
// Occupancy timer for the unpipelined divider: busy for IDIV_LAT-1 cycles after a load.
module exu_idiv_timer #(
  parameter int IDIV_LAT = `IDIV_LATENCY
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic load,
  output logic busy
);

  localparam int CW = $clog2(IDIV_LAT);

  logic [CW-1:0] count;

  // Reaching zero on the writeback cycle lets a following divide issue that same cycle.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(IDIV_LAT - 1);
    end else if (count != '0) begin
      count <= count - CW'(1);
    end
  end

  assign busy = (count != '0);

endmodule

// File: rtl/exu_issue_ctrl.sv
// Issue controller: reservation table that schedules fixed-latency ops onto one writeback port.
module exu_issue_ctrl
  import exu_issue_ctrl_pkg::*;
#(
  parameter int IMUL_LAT = `IMUL_LATENCY,
  parameter int IDIV_LAT = `IDIV_LATENCY,
  parameter int TAG_W    = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             req_valid,
  input  fu_code_t         req_fu,
  input  logic [TAG_W-1:0] req_tag,
  output logic             req_ready,
  output logic             issue_alu,
  output logic             issue_imul,
  output logic             issue_idiv,
  output logic             wb_valid,
  output fu_code_t         wb_fu,
  output logic [TAG_W-1:0] wb_tag,
  output logic             idiv_busy
);

  typedef struct packed {
    logic             valid;
    fu_code_t         fu;
    logic [TAG_W-1:0] tag;
  } slot_t;

  slot_t slots     [IDIV_LAT];
  slot_t slots_nxt [IDIV_LAT];

  logic known_fu;
  logic target_busy;
  logic div_busy;
  logic fire;
  int   lat;

  always_comb begin
    known_fu = 1'b1;
    lat      = 1;
    case (req_fu)
      FU_ALU:  lat = 1;
      FU_IMUL: lat = IMUL_LAT;
      FU_IDIV: lat = IDIV_LAT;
      default: known_fu = 1'b0;
    endcase
  end

  // Slot L (pre-shift) becomes slot L-1 at the edge; IDIV's L lies past the table end.
  always_comb begin
    target_busy = 1'b0;
    for (int i = 1; i < IDIV_LAT; i++) begin
      if (i == lat && slots[i].valid) target_busy = 1'b1;
    end
  end

  // Handshake: req_ready depends only on req_fu and state, never on req_valid;
  // an op is taken exactly when req_valid && req_ready in the same cycle.
  assign req_ready = known_fu && !target_busy && !(req_fu == FU_IDIV && div_busy)
                     && !flush && !reset;
  assign fire       = req_valid && req_ready;
  assign issue_alu  = fire && (req_fu == FU_ALU);
  assign issue_imul = fire && (req_fu == FU_IMUL);
  assign issue_idiv = fire && (req_fu == FU_IDIV);

  always_comb begin
    for (int i = 0; i < IDIV_LAT; i++) slots_nxt[i] = '0;
    for (int i = 0; i < IDIV_LAT - 1; i++) slots_nxt[i] = slots[i+1];
    for (int i = 0; i < IDIV_LAT; i++) begin
      if (fire && i == lat - 1) slots_nxt[i] = '{valid: 1'b1, fu: req_fu, tag: req_tag};
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      for (int i = 0; i < IDIV_LAT; i++) slots[i] <= '0;
    end else begin
      for (int i = 0; i < IDIV_LAT; i++) slots[i] <= slots_nxt[i];
    end
  end

  exu_idiv_timer #(.IDIV_LAT(IDIV_LAT)) u_idiv_timer (
    .clock (clock),
    .reset (reset),
    .clear (flush),
    .load  (issue_idiv),
    .busy  (div_busy)
  );

  assign wb_valid  = slots[0].valid && !flush && !reset;
  assign wb_fu     = wb_valid ? slots[0].fu : FU_ALU;
  assign wb_tag    = wb_valid ? slots[0].tag : '0;
  assign idiv_busy = div_busy && !reset;

endmodule

// File: tb/tb_exu_issue_ctrl.sv
// Directed bench for exu_issue_ctrl at IMUL_LAT=3, IDIV_LAT=8.
module tb_exu_issue_ctrl;
  import exu_issue_ctrl_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       flush = 1'b0;
  logic       req_valid = 1'b0;
  fu_code_t   req_fu = FU_ALU;
  logic [5:0] req_tag = '0;
  logic       req_ready, issue_alu, issue_imul, issue_idiv;
  logic       wb_valid, idiv_busy;
  fu_code_t   wb_fu;
  logic [5:0] wb_tag;

  int checks = 0;
  int errors = 0;

  exu_issue_ctrl #(.IMUL_LAT(3), .IDIV_LAT(8), .TAG_W(6)) dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_fu     (req_fu),
    .req_tag    (req_tag),
    .req_ready  (req_ready),
    .issue_alu  (issue_alu),
    .issue_imul (issue_imul),
    .issue_idiv (issue_idiv),
    .wb_valid   (wb_valid),
    .wb_fu      (wb_fu),
    .wb_tag     (wb_tag),
    .idiv_busy  (idiv_busy)
  );

  // Clock/reset: inputs change on negedge, outputs sampled 1ns later.
  always #5 clock = ~clock;

  task automatic drive_idle();
    flush = 1'b0; req_valid = 1'b0; req_fu = FU_ALU; req_tag = '0;
  endtask

  task automatic do_reset();
    drive_idle();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b1; req_fu = FU_ALU; req_tag = 6'd9;
    @(negedge clock); #1;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got %b want 0", wb_valid); end
    checks++; if (idiv_busy !== 1'b0) begin errors++; $display("FAIL reset_idiv_busy got %b want 0", idiv_busy); end
    checks++; if (issue_alu !== 1'b0) begin errors++; $display("FAIL reset_issue_alu got %b want 0", issue_alu); end
    checks++; if (wb_fu !== FU_ALU) begin errors++; $display("FAIL reset_wb_fu got %0d want 0", wb_fu); end
    checks++; if (wb_tag !== 6'd0) begin errors++; $display("FAIL reset_wb_tag got %0d want 0", wb_tag); end
    @(negedge clock); reset = 1'b0; drive_idle(); #1;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL post_reset_wb_valid got %b want 0", wb_valid); end
  endtask

  task automatic test_alu();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      req_valid = (c == 0); req_fu = FU_ALU; req_tag = 6'd5;
      #1;
      if (c == 0) begin
        checks++; if (req_ready !== 1'b1 || issue_alu !== 1'b1 || issue_imul !== 1'b0 || issue_idiv !== 1'b0) begin
          errors++; $display("FAIL alu_issue c%0d got rdy=%b alu=%b imul=%b idiv=%b want 1 1 0 0", c, req_ready, issue_alu, issue_imul, issue_idiv);
        end
      end
      checks++; if (wb_valid !== (c == 1)) begin errors++; $display("FAIL alu_wb_valid c%0d got %b want %b", c, wb_valid, (c == 1)); end
      if (c == 1) begin
        checks++; if (wb_tag !== 6'd5 || wb_fu !== FU_ALU) begin errors++; $display("FAIL alu_wb c%0d got tag=%0d fu=%0d want 5 0", c, wb_tag, wb_fu); end
      end
    end
    drive_idle();
  endtask

  task automatic test_conflict();
    logic [5:0] e_tag;
    fu_code_t   e_fu;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      drive_idle();
      if (c == 0) begin req_valid = 1'b1; req_fu = FU_IMUL; req_tag = 6'd1; end
      if (c == 2 || c == 3) begin req_valid = 1'b1; req_fu = FU_ALU; req_tag = 6'd2; end
      #1;
      if (c == 2) begin
        checks++; if (req_ready !== 1'b0 || issue_alu !== 1'b0) begin errors++; $display("FAIL conflict_blocked c%0d got rdy=%b alu=%b want 0 0", c, req_ready, issue_alu); end
      end
      if (c == 3) begin
        checks++; if (req_ready !== 1'b1 || issue_alu !== 1'b1) begin errors++; $display("FAIL conflict_accept c%0d got rdy=%b alu=%b want 1 1", c, req_ready, issue_alu); end
      end
      checks++; if (wb_valid !== (c == 3 || c == 4)) begin errors++; $display("FAIL conflict_wb_valid c%0d got %b want %b", c, wb_valid, (c == 3 || c == 4)); end
      if (c == 3 || c == 4) begin
        e_tag = (c == 3) ? 6'd1 : 6'd2;
        e_fu  = (c == 3) ? FU_IMUL : FU_ALU;
        checks++; if (wb_tag !== e_tag || wb_fu !== e_fu) begin errors++; $display("FAIL conflict_wb c%0d got tag=%0d fu=%0d want %0d %0d", c, wb_tag, wb_fu, e_tag, e_fu); end
      end
    end
    drive_idle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int c = 0; c < 7; c++) begin
      @(negedge clock);
      drive_idle();
      if (c < 3) begin req_valid = 1'b1; req_fu = FU_IMUL; req_tag = 6'(c + 1); end
      #1;
      if (c < 3) begin
        checks++; if (req_ready !== 1'b1 || issue_imul !== 1'b1) begin errors++; $display("FAIL b2b_accept c%0d got rdy=%b imul=%b want 1 1", c, req_ready, issue_imul); end
      end
      checks++; if (wb_valid !== (c >= 3 && c <= 5)) begin errors++; $display("FAIL b2b_wb_valid c%0d got %b want %b", c, wb_valid, (c >= 3 && c <= 5)); end
      if (c >= 3 && c <= 5) begin
        checks++; if (wb_tag !== 6'(c - 2) || wb_fu !== FU_IMUL) begin errors++; $display("FAIL b2b_wb c%0d got tag=%0d fu=%0d want %0d 1", c, wb_tag, wb_fu, c - 2); end
      end
    end
    drive_idle();
  endtask

  task automatic test_idiv();
    logic e_busy;
    logic [5:0] e_tag;
    do_reset();
    for (int c = 0; c < 18; c++) begin
      @(negedge clock);
      drive_idle();
      req_fu = FU_IDIV; req_valid = (c <= 8); req_tag = (c == 0) ? 6'd7 : 6'd8;
      #1;
      e_busy = (c >= 1 && c <= 7) || (c >= 9 && c <= 15);
      checks++; if (idiv_busy !== e_busy) begin errors++; $display("FAIL idiv_busy c%0d got %b want %b", c, idiv_busy, e_busy); end
      checks++; if (req_ready !== !e_busy) begin errors++; $display("FAIL idiv_ready c%0d got %b want %b", c, req_ready, !e_busy); end
      checks++; if (issue_idiv !== (c == 0 || c == 8)) begin errors++; $display("FAIL idiv_issue c%0d got %b want %b", c, issue_idiv, (c == 0 || c == 8)); end
      checks++; if (wb_valid !== (c == 8 || c == 16)) begin errors++; $display("FAIL idiv_wb_valid c%0d got %b want %b", c, wb_valid, (c == 8 || c == 16)); end
      if (c == 8 || c == 16) begin
        e_tag = (c == 8) ? 6'd7 : 6'd8;
        checks++; if (wb_tag !== e_tag || wb_fu !== FU_IDIV) begin errors++; $display("FAIL idiv_wb c%0d got tag=%0d fu=%0d want %0d 2", c, wb_tag, wb_fu, e_tag); end
      end
    end
    drive_idle();
  endtask

  task automatic test_flush();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      drive_idle();
      if (c == 0) begin req_valid = 1'b1; req_fu = FU_IMUL; req_tag = 6'd1; end
      if (c == 2) begin flush = 1'b1; req_valid = 1'b1; req_fu = FU_ALU; req_tag = 6'd9; end
      if (c == 3) begin req_valid = 1'b1; req_fu = FU_ALU; req_tag = 6'd4; end
      if (c == 5) begin req_valid = 1'b1; req_fu = FU_ALU; req_tag = 6'd6; end
      if (c == 6) flush = 1'b1;
      #1;
      if (c == 2) begin
        checks++; if (req_ready !== 1'b0 || issue_alu !== 1'b0) begin errors++; $display("FAIL flush_drop c%0d got rdy=%b alu=%b want 0 0", c, req_ready, issue_alu); end
      end
      checks++; if (issue_alu !== (c == 3 || c == 5)) begin errors++; $display("FAIL flush_issue_alu c%0d got %b want %b", c, issue_alu, (c == 3 || c == 5)); end
      checks++; if (wb_valid !== (c == 4)) begin errors++; $display("FAIL flush_wb_valid c%0d got %b want %b", c, wb_valid, (c == 4)); end
      if (c == 4) begin
        checks++; if (wb_tag !== 6'd4 || wb_fu !== FU_ALU) begin errors++; $display("FAIL flush_wb c%0d got tag=%0d fu=%0d want 4 0", c, wb_tag, wb_fu); end
      end
    end
    drive_idle();
  endtask

  task automatic test_reset_mid_idiv();
    logic e_busy;
    do_reset();
    for (int c = 0; c < 14; c++) begin
      @(negedge clock);
      drive_idle();
      req_fu = FU_IDIV;
      reset = (c == 4);
      if (c == 0) begin req_valid = 1'b1; req_tag = 6'd3; end
      if (c == 5) begin req_valid = 1'b1; req_tag = 6'd4; end
      #1;
      e_busy = (c >= 1 && c <= 3) || (c >= 6 && c <= 12);
      checks++; if (idiv_busy !== e_busy) begin errors++; $display("FAIL rst_idiv_busy c%0d got %b want %b", c, idiv_busy, e_busy); end
      checks++; if (wb_valid !== (c == 13)) begin errors++; $display("FAIL rst_idiv_wb_valid c%0d got %b want %b", c, wb_valid, (c == 13)); end
      if (c == 5) begin
        checks++; if (req_ready !== 1'b1 || issue_idiv !== 1'b1) begin errors++; $display("FAIL rst_idiv_accept c%0d got rdy=%b idiv=%b want 1 1", c, req_ready, issue_idiv); end
      end
      if (c == 13) begin
        checks++; if (wb_tag !== 6'd4 || wb_fu !== FU_IDIV) begin errors++; $display("FAIL rst_idiv_wb c%0d got tag=%0d fu=%0d want 4 2", c, wb_tag, wb_fu); end
      end
    end
    reset = 1'b0;
    drive_idle();
  endtask

  task automatic test_bad_code();
    do_reset();
    @(negedge clock);
    req_valid = 1'b1; req_fu = FU_RSVD; req_tag = 6'd11;
    #1;
    checks++; if (req_ready !== 1'b0 || issue_alu !== 1'b0 || issue_imul !== 1'b0 || issue_idiv !== 1'b0) begin
      errors++; $display("FAIL bad_code got rdy=%b alu=%b imul=%b idiv=%b want 0 0 0 0", req_ready, issue_alu, issue_imul, issue_idiv);
    end
    @(negedge clock);
    req_valid = 1'b0; req_fu = FU_IMUL;
    #1;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL bad_code_wb got %b want 0", wb_valid); end
    checks++; if (req_ready !== 1'b1 || issue_imul !== 1'b0) begin errors++; $display("FAIL ready_without_valid got rdy=%b imul=%b want 1 0", req_ready, issue_imul); end
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_conflict();
    test_back_to_back();
    test_idiv();
    test_flush();
    test_reset_mid_idiv();
    test_bad_code();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exu_issue_ctrl.md
EXU_ISSUE_CTRL -- requirements
Module: exu_issue_ctrl

Interface
REQ-001 SHALL have parameter IMUL_LAT, default `IMUL_LATENCY (3): cycles from IMUL issue to writeback, at least 2.
REQ-002 SHALL have parameter IDIV_LAT, default `IDIV_LATENCY (8): cycles from IDIV issue to writeback; IDIV_LAT > IMUL_LAT.
REQ-003 SHALL have parameter TAG_W, default 6: width of the pass-through op tag.
REQ-004 clock  in  1  single clock, all state on posedge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 flush  in  1  kill all in-flight ops.
REQ-007 req_valid  in  1  issue request present.
REQ-008 req_fu  in  fu_code_t  requested functional unit.
REQ-009 req_tag  in  TAG_W  op tag.
REQ-010 req_ready  out  1  request accepted this cycle; fire = req_valid & req_ready.
REQ-011 issue_alu / issue_imul / issue_idiv  out  1 each  one-hot start strobes to the units.
REQ-012 wb_valid  out  1  result on the shared writeback port this cycle.
REQ-013 wb_fu  out  fu_code_t  unit whose result drives the writeback mux.
REQ-014 wb_tag  out  TAG_W  tag of the writeback op.
REQ-015 idiv_busy  out  1  unpipelined divider occupied.

Function
REQ-016 Latency L SHALL be 1 for FU_ALU, IMUL_LAT for FU_IMUL, IDIV_LAT for FU_IDIV; an op fired in cycle t SHALL have wb_valid in cycle t+L.
REQ-017 Reservation table slot[0..IDIV_LAT-1] (valid, fu, tag) SHALL shift down one slot every cycle; wb_valid/wb_fu/wb_tag SHALL be driven from slot[0].
REQ-018 A fire SHALL write slot[L-1] post-shift; req_ready SHALL require pre-shift slot[L] empty (L=IDIV_LAT always free).
REQ-019 FU_IDIV SHALL also require idiv_busy=0; a fire loads a down-counter with IDIV_LAT-1; idiv_busy = counter!=0.
REQ-020 A new IDIV SHALL be acceptable in the same cycle the previous IDIV writes back.
REQ-021 Codes other than ALU/IMUL/IDIV SHALL give req_ready=0.
REQ-022 req_ready SHALL be combinational from req_fu and state, independent of req_valid; issue_* SHALL assert only on fire, same cycle.
REQ-023 flush SHALL force req_ready=0 and wb_valid=0 that cycle and clear all slots and the IDIV counter at the edge.
REQ-024 flush with req_valid SHALL drop the request (no issue strobe).

Reset
REQ-025 Reset SHALL clear all slots and the IDIV counter; during and after reset wb_valid=0, idiv_busy=0, issue_*=0, wb_fu=FU_ALU encoding 0 default, wb_tag=0.
REQ-026 Reset mid-IDIV or mid-IMUL SHALL discard the op; no writeback SHALL follow.

Structure
REQ-027 fu_code_t, `IMUL_LATENCY, `IDIV_LATENCY SHALL come from the shared package; no local redefinition.
REQ-028 Slot entry struct SHALL be local; one sub-module, exu_idiv_timer (down-counter), is permitted.

Verification (IMUL_LAT=3, IDIV_LAT=8)
REQ-029 ALU tag 5 fires cycle 0 -> wb_valid cycle 1, wb_fu=FU_ALU, wb_tag=5, nothing else.
REQ-030 IMUL tag 1 cycle 0, ALU tag 2 requested cycle 2 -> req_ready=0 cycle 2, ALU fires cycle 3; wb tag 1 at 3, tag 2 at 4.
REQ-031 IMUL tags 1,2,3 back-to-back cycles 0-2 -> all accepted, wb tags 1,2,3 in cycles 3,4,5.
REQ-032 IDIV tag 7 cycle 0, IDIV tag 8 held -> idiv_busy cycles 1-7, tag 8 fires cycle 8; wb tag 7 at 8, tag 8 at 16.
REQ-033 IMUL cycle 0, flush cycle 2 -> no wb cycle 3; ALU requested cycle 3 accepted, wb cycle 4.
REQ-034 IDIV cycle 0, reset cycle 4 -> no wb cycles 5-12; idiv_busy=0 from cycle 5; IDIV accepted cycle 5.
